keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Matrix-keypad scanner, the input-side counterpart of the 7-segment scanning display driver. It walks an active-low strobe across the keypad rows and samples the active-low column returns. Each stable key press is debounced and encoded, then delivered to the CPU I/O side through a one-entry valid/ready output register. It sits between the board's keypad pins and the memory-mapped I/O bus.

Parameters:
ROWS, 4, number of keypad rows driven.
COLS, 4, number of keypad columns sensed.
SCAN_DIV, 1000, clk cycles each row is driven; must be >= 4.
DEBOUNCE_SCANS, 8, consecutive identical full frames required to confirm a press or a release; must be >= 1.
CODE_W (localparam), clog2(ROWS*COLS), key code width; 4 at the defaults.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
row_n  out  ROWS  row strobes, active-low, one-cold while scanning.
col_n  in  COLS  column returns, active-low, asynchronous (pulled up on the board).
key_code  out  CODE_W  code of the confirmed key = row*COLS + col.
key_valid  out  1  key_code holds an undelivered press event.
key_ready  in  1  consumer accepts the event when key_valid & key_ready.
key_down  out  1  level output; high while the debounced state is HELD.
overrun  out  1  sticky flag; a press event was dropped.

Behaviour:
- Reset, asynchronous: row_n = all 1; key_code = 0; key_valid = 0; key_down = 0; overrun = 0; row index = 0; divider = 0; state = IDLE; debounce count = 0.
- Synchronisation: col_n passes through a 2-FF synchronizer before any use.
- Scan sequencing:
  - First clk after reset release: row_n = ~(1<<0).
  - Each row is held SCAN_DIV cycles, then the index advances. ROWS-1 wraps to 0.
  - One frame = ROWS*SCAN_DIV cycles.
- Sampling: synced columns are sampled on the divider's last cycle (SCAN_DIV-1) of each row slot, which leaves settling time for the synchronizer.
- Frame classification, evaluated on the cycle after the last row's sample:
  - NONE: no active column anywhere.
  - SINGLE(code): exactly one active row/column crossing.
  - MULTI: two or more crossings, including ghosting.
- Debounce FSM:
  - IDLE
    - SINGLE(c): cand = c, cnt = 1, go to PRESS_CONFIRM. If DEBOUNCE_SCANS = 1, confirm immediately.
    - NONE or MULTI: stay.
  - PRESS_CONFIRM
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, the press is confirmed: emit event(cand), go to HELD.
    - SINGLE(other code): cand = new code, cnt = 1.
    - NONE or MULTI: go to IDLE, cnt = 0.
  - HELD (key_down = 1)
    - NONE: cnt = 1, go to RELEASE_CONFIRM.
    - SINGLE or MULTI: stay. No auto-repeat; a second key added while held is ignored.
  - RELEASE_CONFIRM
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - Anything else: return to HELD. No new event.
- Event emission, in the evaluation cycle:
  - Output register empty (key_valid=0) or being accepted the same cycle (key_ready=1): key_code <= cand, key_valid <= 1. key_valid rises one clk after the evaluation cycle.
  - Otherwise the event is dropped, key_code is unchanged and overrun <= 1.
- Handshake:
  - key_valid stays high and key_code stays stable until key_valid & key_ready; key_valid falls the next cycle unless a simultaneous new event reloads it.
  - key_ready while key_valid=0 has no effect.
- overrun is cleared on the cycle an accept occurs (key_valid & key_ready). If a drop and a clear fall in the same cycle, the drop wins.
- Reset mid-frame or mid-debounce: all state is discarded immediately and any pending event is lost.
- Latency: a clean press held from frame start gives key_valid after DEBOUNCE_SCANS frames, plus the 1 evaluation cycle, plus 1 register cycle.

Decomposition:
- Package keypad_pkg:
  - FSM state enum {IDLE, PRESS_CONFIRM, HELD, RELEASE_CONFIRM}.
  - Frame-class enum {NONE, SINGLE, MULTI}.
  - Default parameter constants.
  - Code-width function.
- Sub-module sync2: a parameterised-width 2-FF synchronizer with asynchronous active-low reset (rst_n). Instantiate it once for col_n.

Test Plan:
Use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3 (frame = 16 cycles) for all scenarios.
1. Scan: release reset with no keys pressed -> row_n cycles 1110,1101,1011,0111, each row held 4 cycles, repeating; key_valid stays 0 and key_down stays 0.
2. Clean press: model the key at row 2 / col 1 pulling col_n[1] low while row_n[2]=0, held for 5 frames, key_ready=1 -> a single key_valid pulse with key_code=9 after 3 frames + 2 cycles; key_down=1 until 3 NONE frames follow the release.
3. Bounce: toggle the key every frame for 4 frames, then hold it steady -> no event during the bounce; exactly one event (code 9) 3 frames after it stabilises.
4. Backpressure: key_ready=0; press key 9, release it, then press key 4 (row 1 / col 0) -> key_code stays 9 with key_valid=1 and overrun=1; raise key_ready for 1 cycle -> key_valid=0 and overrun=0.
5. Ghosting and held behaviour: press row 0/col 0 and row 1/col 1 together from IDLE -> no event; press key 0 alone to HELD, then add key 5 -> still one event (code 0), and key_down stays 1.
6. Reset mid-confirm: after 2 matching frames, pulse rst_n low for 1 cycle -> all outputs at their reset values immediately; the key still held gives an event only after 3 new full frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and defaults for the matrix keypad scanner.
// Imported by the scanner top and its testbench.
package keypad_pkg;

  localparam int DEF_ROWS           = 4;
  localparam int DEF_COLS           = 4;
  localparam int DEF_SCAN_DIV       = 1000;
  localparam int DEF_DEBOUNCE_SCANS = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CONFIRM,
    HELD,
    RELEASE_CONFIRM
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_class_e;

  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
// The reset value is a parameter so idle pulled-up inputs can reset to all ones.
module sync2 #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row strobing, frame classification, press/release
// debounce and a one-entry valid/ready event register toward the CPU side.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int  ROWS           = DEF_ROWS,
  parameter int  COLS           = DEF_COLS,
  parameter int  SCAN_DIV       = DEF_SCAN_DIV,
  parameter int  DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
  localparam int CODE_W         = code_width(ROWS, COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROWS-1:0]   row_n,
  input  logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_down,
  output logic              overrun,
  output kp_state_e         state_dbg
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic              run;
  logic [DIV_W-1:0]  div;
  logic [ROW_W-1:0]  row_idx;
  logic              sample;
  logic              last_row;
  logic [COLS-1:0]   col_s;
  logic [ROWS*COLS-1:0] hits;
  logic              eval;

  assign sample   = run && (div == DIV_W'(SCAN_DIV - 1));
  assign last_row = (row_idx == ROW_W'(ROWS - 1));

  // run holds the strobes inactive until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      div     <= '0;
      row_idx <= '0;
    end else begin
      run <= 1'b1;
      if (sample) begin
        div     <= '0;
        row_idx <= last_row ? '0 : row_idx + ROW_W'(1);
      end else if (run) begin
        div <= div + DIV_W'(1);
      end
    end
  end

  always_comb begin
    row_n = '1;
    if (run) row_n[row_idx] = 1'b0;
  end

  sync2 #(.W(COLS), .RST_VAL({COLS{1'b1}})) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_n),
    .q     (col_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits <= '0;
      eval <= 1'b0;
    end else begin
      if (sample) hits[row_idx*COLS +: COLS] <= ~col_s;
      eval <= sample && last_row;
    end
  end

  // Saturating hit count: only 0, 1 and "2 or more" matter.
  logic [1:0]        n_hits;
  logic [CODE_W-1:0] f_code;
  frame_class_e      fclass;

  always_comb begin
    n_hits = 2'd0;
    f_code = '0;
    for (int i = 0; i < ROWS*COLS; i++) begin
      if (hits[i]) begin
        if (n_hits != 2'd2) n_hits = n_hits + 2'd1;
        f_code = CODE_W'(i);
      end
    end
    fclass = (n_hits == 2'd0) ? NONE : (n_hits == 2'd1) ? SINGLE : MULTI;
  end

  kp_state_e         state, state_nx;
  logic [CODE_W-1:0] cand, cand_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              emit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    emit     = 1'b0;
    if (eval) begin
      case (state)
        IDLE: begin
          if (fclass == SINGLE) begin
            cand_nx = f_code;
            if (DEBOUNCE_SCANS == 1) begin
              emit     = 1'b1;
              state_nx = HELD;
              cnt_nx   = '0;
            end else begin
              cnt_nx   = CNT_W'(1);
              state_nx = PRESS_CONFIRM;
            end
          end
        end
        PRESS_CONFIRM: begin
          if (fclass == SINGLE && f_code == cand) begin
            cnt_nx = cnt + CNT_W'(1);
            if (cnt_nx == CNT_W'(DEBOUNCE_SCANS)) begin
              emit     = 1'b1;
              state_nx = HELD;
              cnt_nx   = '0;
            end
          end else if (fclass == SINGLE) begin
            cand_nx = f_code;
            cnt_nx  = CNT_W'(1);
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        HELD: begin
          if (fclass == NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              state_nx = RELEASE_CONFIRM;
              cnt_nx   = CNT_W'(1);
            end
          end
        end
        RELEASE_CONFIRM: begin
          if (fclass == NONE) begin
            cnt_nx = cnt + CNT_W'(1);
            if (cnt_nx == CNT_W'(DEBOUNCE_SCANS)) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end
          end else begin
            state_nx = HELD;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Handshake: an event transfers on a cycle with key_valid & key_ready;
  // key_code is held stable while key_valid is high and not yet accepted.
  logic accept;
  logic load;

  assign accept = key_valid & key_ready;
  assign load   = emit & (~key_valid | key_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        key_code  <= cand_nx;
        key_valid <= 1'b1;
      end else if (accept) begin
        key_valid <= 1'b0;
      end
      if (emit && !load) overrun <= 1'b1;
      else if (accept)   overrun <= 1'b0;
    end
  end

  assign key_down  = (state == HELD) || (state == RELEASE_CONFIRM);
  assign state_dbg = state;

endmodule
